// File: rtl/uartlite_responder_if.sv
// AXI4-Lite bundle between the CPU-side initiator and the UART-Lite responder.
// Address space is 4 bits wide; only bits [3:2] select a register.
interface uartlite_responder_if;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/uartlite_responder.sv
// UART-Lite compatible AXI4-Lite responder: RX FIFO (0x0), TX FIFO (0x4),
// STAT (0x8), CTRL (0xC). Bytes arrive from the serial core without
// back-pressure and leave through a valid/ready stream.
// Optional feature macro: UARTLITE_RXERR_EN enables the sticky frame/parity
// error bits STAT[6]/STAT[7]; without it those bits read as 0.
module uartlite_responder #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  uartlite_responder_if.slave  bus,
  input  logic [7:0]           rx_data,
  input  logic                 rx_vld,
  input  logic                 rx_frame_err,
  input  logic                 rx_parity_err,
  output logic [7:0]           tx_data,
  output logic                 tx_vld,
  input  logic                 tx_rdy
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] A_RX   = 2'd0;
  localparam logic [1:0] A_TX   = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef logic [DEPTH_BITS:0] ptr_t;
  typedef enum logic { R_IDLE, R_RESP } rstate_t;
  typedef enum logic { W_IDLE, W_RESP } wstate_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0] r_rx_mem [DEPTH];
  logic [7:0] r_tx_mem [DEPTH];
  ptr_t       r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;

  // Status/control
  logic       r_intr_en, r_overrun, r_frame_err, r_parity_err;
  logic [7:0] w_stat;

  // Read channel
  rstate_t     r_rstate;
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs, w_rx_pop, w_stat_clr;
  logic [1:0]  w_rd_addr;

  // Write channel
  wstate_t    r_wstate;
  logic       r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [1:0] r_bresp, r_awaddr;
  logic [7:0] r_wdata;
  logic       r_wstrb0;
  logic       w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_wr_exec;
  logic [1:0] w_wr_addr;
  logic [7:0] w_wr_data;
  logic       w_wr_strb0;
  logic       w_tx_push, w_tx_pop, w_ctrl_wr, w_tx_rst, w_rx_rst;
  logic       w_rx_push, w_overrun_set, w_frame_set, w_parity_set;
  logic       w_unused;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[DEPTH_BITS] != r_rx_rptr[DEPTH_BITS]) &&
                      (r_rx_wptr[DEPTH_BITS-1:0] == r_rx_rptr[DEPTH_BITS-1:0]);
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[DEPTH_BITS] != r_tx_rptr[DEPTH_BITS]) &&
                      (r_tx_wptr[DEPTH_BITS-1:0] == r_tx_rptr[DEPTH_BITS-1:0]);

  assign w_stat = {r_parity_err, r_frame_err, r_overrun, r_intr_en,
                   w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

  // Read-side decode at the AR handshake
  assign w_ar_hs    = bus.s_axi_arvalid & r_arready;
  assign w_rd_addr  = bus.s_axi_araddr[3:2];
  assign w_rx_pop   = w_ar_hs & (w_rd_addr == A_RX) & ~w_rx_empty;
  assign w_stat_clr = w_ar_hs & (w_rd_addr == A_STAT);

  // Write-side merge of captured and in-flight AW/W beats
  assign w_aw_hs    = bus.s_axi_awvalid & r_awready;
  assign w_w_hs     = bus.s_axi_wvalid & r_wready;
  assign w_have_aw  = r_aw_held | w_aw_hs;
  assign w_have_w   = r_w_held | w_w_hs;
  assign w_wr_exec  = (r_wstate == W_IDLE) & w_have_aw & w_have_w;
  assign w_wr_addr  = r_aw_held ? r_awaddr : bus.s_axi_awaddr[3:2];
  assign w_wr_data  = r_w_held ? r_wdata : bus.s_axi_wdata[7:0];
  assign w_wr_strb0 = r_w_held ? r_wstrb0 : bus.s_axi_wstrb[0];

  assign w_tx_push = w_wr_exec & (w_wr_addr == A_TX) & w_wr_strb0 & ~w_tx_full;
  assign w_ctrl_wr = w_wr_exec & (w_wr_addr == A_CTRL) & w_wr_strb0;
  assign w_tx_rst  = w_ctrl_wr & w_wr_data[0];
  assign w_rx_rst  = w_ctrl_wr & w_wr_data[1];
  assign w_tx_pop  = ~w_tx_empty & tx_rdy;

  // Full is judged on pre-edge occupancy, so a push to a full FIFO is lost
  // even when a pop happens on the same edge.
  assign w_rx_push     = rx_vld & ~w_rx_full;
  assign w_overrun_set = rx_vld & w_rx_full;
`ifdef UARTLITE_RXERR_EN
  assign w_frame_set  = rx_vld & rx_frame_err;
  assign w_parity_set = rx_vld & rx_parity_err;
`else
  assign w_frame_set  = 1'b0;
  assign w_parity_set = 1'b0;
`endif

  assign w_unused = ^{bus.s_axi_araddr[1:0], bus.s_axi_awaddr[1:0],
                      bus.s_axi_wdata[31:8], bus.s_axi_wstrb[3:1],
                      rx_frame_err, rx_parity_err};

  assign tx_vld  = ~w_tx_empty;
  assign tx_data = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr[DEPTH_BITS-1:0]];

  assign bus.s_axi_arready = r_arready;
  assign bus.s_axi_rvalid  = r_rvalid;
  assign bus.s_axi_rdata   = r_rdata;
  assign bus.s_axi_rresp   = r_rresp;
  assign bus.s_axi_awready = r_awready;
  assign bus.s_axi_wready  = r_wready;
  assign bus.s_axi_bvalid  = r_bvalid;
  assign bus.s_axi_bresp   = r_bresp;

  // FIFO data arrays
  // NOTE: storage is deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[DEPTH_BITS-1:0]] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr[DEPTH_BITS-1:0]] <= w_wr_data;
  end

  // FIFO pointers; a CTRL reset overrides any same-cycle push/pop
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_rx_rst) begin
        r_rx_wptr <= '0;
        r_rx_rptr <= '0;
      end else begin
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      end
      if (w_tx_rst) begin
        r_tx_wptr <= '0;
        r_tx_rptr <= '0;
      end else begin
        if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
        if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      end
    end
  end

  // Interrupt enable and sticky error bits; a set wins over a STAT-read clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_intr_en    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_intr_en <= w_wr_data[4];
      r_overrun    <= w_overrun_set | (r_overrun & ~w_stat_clr);
      r_frame_err  <= w_frame_set | (r_frame_err & ~w_stat_clr);
      r_parity_err <= w_parity_set | (r_parity_err & ~w_stat_clr);
    end
  end

  // Read FSM: accept AR, register the response, hold it until R handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            case (w_rd_addr)
              A_RX: begin
                r_rdata <= w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rptr[DEPTH_BITS-1:0]]};
                r_rresp <= RESP_OKAY;
              end
              A_STAT: begin
                r_rdata <= {24'h0, w_stat};
                r_rresp <= RESP_OKAY;
              end
              default: begin
                r_rdata <= 32'h0;
                r_rresp <= RESP_SLVERR;
              end
            endcase
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.s_axi_rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, execute once both are present
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb0  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) r_awaddr <= bus.s_axi_awaddr[3:2];
          if (w_w_hs) begin
            r_wdata  <= bus.s_axi_wdata[7:0];
            r_wstrb0 <= bus.s_axi_wstrb[0];
          end
          if (w_wr_exec) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= (w_wr_addr == A_TX || w_wr_addr == A_CTRL) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_aw_held <= w_have_aw;
            r_w_held  <= w_have_w;
            r_awready <= ~w_have_aw;
            r_wready  <= ~w_have_w;
          end
        end
        W_RESP: begin
          if (bus.s_axi_bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uartlite_responder.sv
// Directed bench for uartlite_responder: reset state, register reads, TX
// stream, RX overflow/drain, split AW/W CTRL write, SLVERR decode, RX error
// bits (build-dependent) and mid-transaction reset.
module tb_uartlite_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_vld, rx_frame_err, rx_parity_err;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy;

  int n_cmp = 0;
  int n_err = 0;

  uartlite_responder_if bus ();

  uartlite_responder #(.DEPTH(16), .DEPTH_BITS(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus.slave),
    .rx_data       (rx_data),
    .rx_vld        (rx_vld),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .tx_data       (tx_data),
    .tx_vld        (tx_vld),
    .tx_rdy        (tx_rdy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AXI read; also checks rvalid is up the cycle after the AR handshake
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cnt = 0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    while (!bus.s_axi_arready && cnt < 20) begin
      step();
      cnt++;
    end
    if (cnt >= 20) check("ar_timeout", 32'(bus.s_axi_arready), 32'd1);
    step();
    bus.s_axi_arvalid = 1'b0;
    check("rvalid_latency", 32'(bus.s_axi_rvalid), 32'd1);
    data = bus.s_axi_rdata;
    resp = bus.s_axi_rresp;
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
  endtask

  // AXI write with AW and W presented together
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int  cnt = 0;
    logic aw_fire, w_fire;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata   = data;
    bus.s_axi_wstrb   = strb;
    bus.s_axi_wvalid  = 1'b1;
    while ((bus.s_axi_awvalid || bus.s_axi_wvalid) && cnt < 20) begin
      aw_fire = bus.s_axi_awvalid & bus.s_axi_awready;
      w_fire  = bus.s_axi_wvalid & bus.s_axi_wready;
      step();
      cnt++;
      if (aw_fire) bus.s_axi_awvalid = 1'b0;
      if (w_fire)  bus.s_axi_wvalid  = 1'b0;
    end
    if (cnt >= 20) begin
      check("aw_w_timeout", 32'(bus.s_axi_awvalid | bus.s_axi_wvalid), 32'd0);
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
    end
    check("bvalid_latency", 32'(bus.s_axi_bvalid), 32'd1);
    resp = bus.s_axi_bresp;
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [7:0]  exp_err;

    rstn = 1'b0;
    rx_data = '0; rx_vld = 1'b0; rx_frame_err = 1'b0; rx_parity_err = 1'b0;
    tx_rdy = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
    check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
    check("rst_wready",  32'(bus.s_axi_wready),  32'd0);
    check("rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
    check("rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
    check("rst_rdata",   bus.s_axi_rdata,        32'd0);
    check("rst_resps",   32'({bus.s_axi_rresp, bus.s_axi_bresp}), 32'd0);
    check("rst_tx_vld",  32'(tx_vld),  32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rstn = 1'b1;
    step();
    check("arready_after_rst", 32'(bus.s_axi_arready), 32'd1);
    check("awready_after_rst", 32'(bus.s_axi_awready), 32'd1);

    // STAT after reset
    axi_read(4'h8, rd, rs);
    check("stat_reset", rd, 32'h0000_0004);
    check("stat_reset_resp", 32'(rs), 32'd0);

    // TX path: two writes held back, then streamed out on consecutive cycles
    axi_write(4'h4, 32'h41, 4'h1, rs);
    check("tx_wr_resp", 32'(rs), 32'd0);
    check("tx_vld_after_wr", 32'(tx_vld), 32'd1);
    axi_write(4'h4, 32'h42, 4'hF, rs);
    axi_read(4'h8, rd, rs);
    check("stat_tx_busy", rd, 32'h0000_0000);
    tx_rdy = 1'b1;
    check("tx_head0", 32'(tx_data), 32'h41);
    step();
    check("tx_head1", 32'(tx_data), 32'h42);
    check("tx_vld_mid", 32'(tx_vld), 32'd1);
    step();
    check("tx_drained", 32'(tx_vld), 32'd0);
    tx_rdy = 1'b0;
    axi_read(4'h8, rd, rs);
    check("stat_tx_empty", rd, 32'h0000_0004);

    // Write with wstrb[0]=0 is dropped
    axi_write(4'h4, 32'h55, 4'hE, rs);
    check("tx_strb0_resp", 32'(rs), 32'd0);
    check("tx_strb0_drop", 32'(tx_vld), 32'd0);

    // Park one TX byte so STAT[2]=0 during the RX overflow test
    axi_write(4'h4, 32'h99, 4'h1, rs);

    // 17 RX pushes: 16 stored, the 17th overruns
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h10 + 8'(i);
      rx_vld  = 1'b1;
      step();
    end
    rx_vld = 1'b0;
    axi_read(4'h8, rd, rs);
    check("stat_rx_overrun", rd, 32'h0000_0023);
    for (int i = 0; i < 16; i++) begin
      axi_read(4'h0, rd, rs);
      check($sformatf("rx_byte%0d", i), rd, 32'h10 + 32'(i));
    end
    axi_read(4'h0, rd, rs);
    check("rx_empty_read", rd, 32'h0);
    check("rx_empty_resp", 32'(rs), 32'd0);
    axi_read(4'h8, rd, rs);
    check("stat_overrun_clr", rd, 32'h0000_0000);

    // Split CTRL write: AW on cycle 1, W on cycle 4 -> bvalid from cycle 5
    rx_data = 8'hA5; rx_vld = 1'b1;
    step();
    rx_vld = 1'b0;
    bus.s_axi_awaddr = 4'hC; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    check("split_awready_low", 32'(bus.s_axi_awready), 32'd0);
    check("split_wready_high", 32'(bus.s_axi_wready), 32'd1);
    step();
    step();
    check("split_no_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    bus.s_axi_wdata = 32'h13; bus.s_axi_wstrb = 4'h1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_wvalid = 1'b0;
    check("split_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    check("split_bresp", 32'(bus.s_axi_bresp), 32'd0);
    check("split_tx_flushed", 32'(tx_vld), 32'd0);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    axi_read(4'h8, rd, rs);
    check("stat_after_ctrl", rd, 32'h0000_0014);

    // Unmapped directions give SLVERR and change nothing
    axi_read(4'h4, rd, rs);
    check("rd_tx_slverr", 32'(rs), 32'd2);
    check("rd_tx_data", rd, 32'h0);
    axi_read(4'hC, rd, rs);
    check("rd_ctrl_slverr", 32'(rs), 32'd2);
    axi_write(4'h8, 32'hFF, 4'hF, rs);
    check("wr_stat_slverr", 32'(rs), 32'd2);
    axi_write(4'h0, 32'h03, 4'hF, rs);
    check("wr_rx_slverr", 32'(rs), 32'd2);
    axi_read(4'h8, rd, rs);
    check("stat_unchanged", rd, 32'h0000_0014);

    // RX error bits: clear intr_en and park a TX byte, then a parity pulse
    axi_write(4'hC, 32'h00, 4'h1, rs);
    axi_write(4'h4, 32'h77, 4'h1, rs);
    rx_data = 8'h5A; rx_vld = 1'b1; rx_parity_err = 1'b1;
    step();
    rx_vld = 1'b0; rx_parity_err = 1'b0;
`ifdef UARTLITE_RXERR_EN
    exp_err = 8'h81;
`else
    exp_err = 8'h01;
`endif
    axi_read(4'h8, rd, rs);
    check("stat_parity", rd, {24'h0, exp_err});
    axi_read(4'h8, rd, rs);
    check("stat_parity_clr", rd, 32'h0000_0001);
    axi_read(4'h0, rd, rs);
    check("rx_err_byte_kept", rd, 32'h5A);

    // Reset while a read response is pending aborts everything
    bus.s_axi_araddr = 4'h8; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    check("pending_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
    rstn = 1'b0;
    step();
    check("abort_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("abort_tx_vld", 32'(tx_vld), 32'd0);
    rstn = 1'b1;
    step();
    axi_read(4'h8, rd, rs);
    check("stat_after_abort", rd, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
